// File: rtl/weight_mem_arbiter_pkg.sv
// snn_pkg: shared types, nibble limits, requester indices and the saturating
// signed 4-bit adder used by the weight arbiter and the learning core.
package snn_pkg;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPD_WR = 2'd1
   } state_t;
   localparam int NIB_MAX = 7;
   localparam int NIB_MIN = -8;
   localparam int REQ_RD  = 0;
   localparam int REQ_UPD = 1;
   localparam int REQ_LD  = 2;
   // a + b as signed 4-bit values, clamped to [NIB_MIN, NIB_MAX]
   function automatic logic [3:0] sat_add_s4(input logic [3:0] a, input logic [3:0] b);
      logic signed [4:0] s;
      s = $signed({a[3], a}) + $signed({b[3], b});
      return (int'(s) > NIB_MAX) ? 4'(NIB_MAX) : (int'(s) < NIB_MIN) ? 4'(NIB_MIN) : s[3:0];
   endfunction
endpackage

// File: rtl/weight_mem_arbiter_if.sv
// weight_mem_arbiter_if: request/response bundle between the three weight
// requesters (master) and the weight memory arbiter (slave).
//   rd_*  : inference read channel (req/addr in, valid/data out)
//   upd_* : learning read-modify-write (req/addr/delta in, busy/done out)
//   ld_*  : host loader (req/addr/data in, ack out)
//   drop_err : sticky {ld, upd, rd} dropped-request flags
interface weight_mem_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DW     = 8
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DW-1:0]     rd_data;
   logic              upd_req;
   logic [ADDR_W-1:0] upd_addr;
   logic [DW-1:0]     upd_delta;
   logic              upd_busy;
   logic              upd_done;
   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [DW-1:0]     ld_data;
   logic              ld_ack;
   logic [2:0]        drop_err;
   modport master (
      output rd_req, rd_addr, upd_req, upd_addr, upd_delta, ld_req, ld_addr, ld_data,
      input  rd_valid, rd_data, upd_busy, upd_done, ld_ack, drop_err
   );
   modport slave (
      input  rd_req, rd_addr, upd_req, upd_addr, upd_delta, ld_req, ld_addr, ld_data,
      output rd_valid, rd_data, upd_busy, upd_done, ld_ack, drop_err
   );
endinterface

// File: rtl/weight_mem_arbiter_rf.sv
// wmem_rf: weight register file, reset to zero, one write port, one
// combinational read port.
//   clk, rst_n : clock, async active-low reset
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module wmem_rf #(
   parameter int ADDR_W = 4,
   parameter int DW     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DW-1:0]     wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DW-1:0]     rdata
);
   logic [DW-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mem <= '{default: '0};
      else if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/weight_mem_arbiter.sv
// weight_mem_arbiter: shares the weight register file between the inference
// read channel, the saturating learning updater and the host loader.
//   clk, rst_n : clock, async active-low reset
//   bus        : weight_mem_arbiter_if slave (rd_*, upd_*, ld_*, drop_err)
module weight_mem_arbiter
   import snn_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int DW         = 8,
   parameter int STARVE_LIM = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   weight_mem_arbiter_if.slave bus
);
   state_t            state, state_nx;
   logic              pend_rd, pend_upd, pend_ld;
   logic [ADDR_W-1:0] rd_addr_q, upd_addr_q, ld_addr_q, upd_wa, waddr, raddr;
   logic [DW-1:0]     upd_delta_q, ld_data_q, upd_word, upd_dlt, new_word, wdata, rdata;
   logic [3:0]        starve_cnt;
   logic              idle, force_upd, gnt_rd, gnt_upd, gnt_ld, we;
   logic              rd_valid, upd_done, ld_ack;
   logic [DW-1:0]     rd_data;
   logic [2:0]        drop_err;

   wmem_rf #(.ADDR_W(ADDR_W), .DW(DW)) u_rf (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata)
   );

   always_comb begin
      idle      = state == S_IDLE;
      force_upd = pend_upd && starve_cnt == 4'(STARVE_LIM);
      gnt_ld    = idle && pend_ld && !force_upd;
      gnt_rd    = idle && pend_rd && !pend_ld && !force_upd;
      gnt_upd   = idle && pend_upd && (force_upd || (!pend_ld && !pend_rd));
      new_word  = {sat_add_s4(upd_word[7:4], upd_dlt[7:4]), sat_add_s4(upd_word[3:0], upd_dlt[3:0])};
      we        = gnt_ld || state == S_UPD_WR;
      waddr     = gnt_ld ? ld_addr_q : upd_wa;
      wdata     = gnt_ld ? ld_data_q : new_word;
      raddr     = gnt_upd ? upd_addr_q : rd_addr_q;
      state_nx  = gnt_upd ? S_UPD_WR : S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;

   // Capture: a new request is taken when nothing is pending or the pending
   // one is granted this cycle; otherwise it is dropped and flagged.
   // The update operands are copied at grant so a request accepted in the
   // grant cycle cannot disturb the following write-back.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {pend_rd, pend_upd, pend_ld} <= '0;
         {rd_addr_q, upd_addr_q, ld_addr_q, upd_wa} <= '0;
         {upd_delta_q, ld_data_q, upd_word, upd_dlt} <= '0;
         starve_cnt <= '0;
         {rd_valid, upd_done, ld_ack} <= '0;
         rd_data <= '0;
         drop_err <= '0;
      end else begin
         if (bus.rd_req && (!pend_rd || gnt_rd)) begin
            pend_rd   <= 1'b1;
            rd_addr_q <= bus.rd_addr;
         end else if (gnt_rd) pend_rd <= 1'b0;
         else if (bus.rd_req) drop_err[REQ_RD] <= 1'b1;
         if (bus.upd_req && (!pend_upd || gnt_upd)) begin
            pend_upd    <= 1'b1;
            upd_addr_q  <= bus.upd_addr;
            upd_delta_q <= bus.upd_delta;
         end else if (gnt_upd) pend_upd <= 1'b0;
         else if (bus.upd_req) drop_err[REQ_UPD] <= 1'b1;
         if (bus.ld_req && (!pend_ld || gnt_ld)) begin
            pend_ld   <= 1'b1;
            ld_addr_q <= bus.ld_addr;
            ld_data_q <= bus.ld_data;
         end else if (gnt_ld) pend_ld <= 1'b0;
         else if (bus.ld_req) drop_err[REQ_LD] <= 1'b1;
         rd_valid <= gnt_rd;
         if (gnt_rd) rd_data <= rdata;
         ld_ack <= gnt_ld;
         if (gnt_upd) begin
            upd_word <= rdata;
            upd_wa   <= upd_addr_q;
            upd_dlt  <= upd_delta_q;
         end
         upd_done   <= state == S_UPD_WR;
         starve_cnt <= gnt_upd ? 4'd0 : (idle && pend_upd && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
      end

   assign bus.rd_valid = rd_valid;
   assign bus.rd_data  = rd_data;
   assign bus.upd_busy = pend_upd || state == S_UPD_WR;
   assign bus.upd_done = upd_done;
   assign bus.ld_ack   = ld_ack;
   assign bus.drop_err = drop_err;
endmodule
